// File: rtl/ram_stream_reader.sv
// ram_stream_reader: burst reader for a registered-read RAM, streaming words through a 2-entry skid FIFO.
module ram_stream_reader #(
   parameter int WIDTH_P = 8,
   parameter int DEPTH_P = 512
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       start_i,
   input  logic [$clog2(DEPTH_P)-1:0] base_addr_i,
   input  logic [$clog2(DEPTH_P):0]   len_i,
   output logic                       rd_en_o,
   output logic [$clog2(DEPTH_P)-1:0] rd_addr_o,
   input  logic [WIDTH_P-1:0]         rd_data_i,
   output logic [WIDTH_P-1:0]         data_o,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic                       busy_o,
   output logic                       done_o
);
   localparam int AW = $clog2(DEPTH_P);
   localparam int LW = AW + 1;
   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
   state_t state;
   logic [AW-1:0] addr;
   logic [LW-1:0] remain, len_sat;
   logic inflight, wr_ptr, rd_ptr, push, pop, rd_en, done_q;
   logic [1:0] cnt, cnt_nxt;
   logic [WIDTH_P-1:0] mem [2];
   // A read is only issued when its data is guaranteed a FIFO slot on arrival.
   always_comb begin
      len_sat = (len_i > LW'(DEPTH_P)) ? LW'(DEPTH_P) : len_i;
      push = inflight;
      valid_o = !rst_i && cnt != 2'd0;
      pop = valid_o && ready_i;
      rd_en = !rst_i && state == READ && remain != '0 && ((3'(cnt) + 3'(inflight)) < 3'd2 || pop);
      cnt_nxt = cnt + 2'(push) - 2'(pop);
      rd_en_o = rd_en;
      rd_addr_o = rst_i ? '0 : addr;
      data_o = valid_o ? mem[rd_ptr] : '0;
      busy_o = !rst_i && state != IDLE;
      done_o = !rst_i && done_q;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         addr <= '0;
         remain <= '0;
         inflight <= 1'b0;
         cnt <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         done_q <= 1'b0;
      end else begin
         inflight <= rd_en;
         cnt <= cnt_nxt;
         done_q <= 1'b0;
         if (push) begin
            mem[wr_ptr] <= rd_data_i;
            wr_ptr <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         if (rd_en) begin
            addr <= (addr == AW'(DEPTH_P - 1)) ? '0 : addr + AW'(1);
            remain <= remain - LW'(1);
         end
         case (state)
            IDLE:
               if (start_i) begin
                  if (len_sat == '0) done_q <= 1'b1;
                  else begin
                     addr <= base_addr_i;
                     remain <= len_sat;
                     state <= READ;
                  end
               end
            READ: if (rd_en && remain == LW'(1)) state <= DRAIN;
            DRAIN:
               if (cnt_nxt == 2'd0) begin
                  state <= IDLE;
                  done_q <= 1'b1;
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: directed bench with a registered-read RAM model and hand-computed expectations.
module tb_ram_stream_reader;
   logic clk = 1'b0;
   logic rst_i, start_i, ready_i;
   logic [8:0] base_addr_i;
   logic [9:0] len_i;
   logic rd_en_o, valid_o, busy_o, done_o;
   logic [8:0] rd_addr_o;
   logic [7:0] rd_data, data_o;
   logic [7:0] ram [512];
   logic [20:0] outs;
   int n_chk = 0, n_pass = 0;
   int n, first_v, last_p, issued, popped;
   int words[$], addrs[$], dones[$];
   logic busy_done, pv, pr;
   logic [7:0] pd;
   logic [15:0] lfsr = 16'hACE1;

   always #5 clk = ~clk;

   ram_stream_reader #(.WIDTH_P(8), .DEPTH_P(512)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i), .len_i(len_i),
      .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data), .data_o(data_o),
      .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o), .done_o(done_o));

   always_ff @(posedge clk) if (rd_en_o) rd_data <= ram[rd_addr_o];

   assign outs = {rd_en_o, rd_addr_o, valid_o, data_o, busy_o, done_o};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
   endtask

   function automatic int exp_word(input int a);
      return (a % 512 + 16) % 256;
   endfunction

   task automatic clear();
      n = 0; first_v = -1; last_p = -1; issued = 0; popped = 0; pv = 0; pr = 0; busy_done = 1'b1;
      words.delete(); addrs.delete(); dones.delete();
   endtask

   // Samples the current cycle mid-period, then advances to just after the next rising edge.
   task automatic cyc(input bit zero = 0);
      #1;
      if (zero) check("outputs_zero", 32'(outs), 0);
      if (!rst_i) begin
         if (pv && !pr) check("hold_stable", {valid_o, data_o}, {1'b1, pd});
         if (rd_en_o) begin addrs.push_back(int'(rd_addr_o)); issued++; end
         if (valid_o && ready_i) begin
            words.push_back(int'(data_o)); popped++; last_p = n;
            if (first_v < 0) first_v = n;
         end
         if (rd_en_o) check("outstanding_le2", 32'(issued - popped <= 2), 1);
         if (done_o) begin dones.push_back(n); busy_done = busy_o; end
         pv = valid_o; pr = ready_i; pd = data_o;
      end else begin
         pv = 0; issued = 0; popped = 0;
      end
      n++;
      @(posedge clk); #1;
   endtask

   task automatic burst(input int base, input int len, input int mode, input int budget);
      clear();
      start_i = 1; base_addr_i = 9'(base); len_i = 10'(len); ready_i = 1;
      cyc();
      start_i = 0;
      while (dones.size() == 0 && n < budget) begin
         lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         ready_i = (mode == 0) ? 1'b1 : (n >= 8 && n < 18) ? 1'b0 : lfsr[0];
         cyc();
      end
      if (dones.size() == 0) check("timeout", 0, 1);
      ready_i = 1;
   endtask

   task automatic verify(input int base, input int len);
      int l;
      l = len > 512 ? 512 : len;
      check("nwords", words.size(), l);
      check("naddrs", addrs.size(), l);
      for (int i = 0; i < l && i < words.size(); i++) check("word", words[i], exp_word(base + i));
      for (int i = 0; i < l && i < addrs.size(); i++) check("addr", addrs[i], (base + i) % 512);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int ea[8];
      ea = '{20, 21, 22, 40, 41, 42, 43, 44};
      for (int i = 0; i < 512; i++) ram[i] = 8'(i + 16);
      rst_i = 1; start_i = 0; ready_i = 0; base_addr_i = 0; len_i = 0;
      clear();
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) cyc(1);
      rst_i = 0;
      for (int i = 0; i < 5; i++) cyc(1);

      burst(4, 8, 0, 40);
      verify(4, 8);
      check("first_valid_cycle", first_v, 3);
      check("done_cycle", dones.size() > 0 ? dones[0] : -1, 11);
      check("busy_at_done", busy_done, 0);
      check("contiguous", last_p - first_v + 1, 8);
      cyc();
      check("done_once", dones.size(), 1);

      burst(100, 16, 1, 120);
      verify(100, 16);
      cyc(); cyc();
      check("bp_done_once", dones.size(), 1);

      burst(510, 4, 0, 30);
      verify(510, 4);

      burst(0, 600, 0, 600);
      verify(0, 600);

      burst(7, 0, 0, 10);
      verify(7, 0);
      check("len0_done_cycle", dones.size() > 0 ? dones[0] : -1, 1);

      clear();
      for (int c = 0; c < 17; c++) begin
         start_i = c < 14;
         base_addr_i = c == 0 ? 9'd20 : c == 6 ? 9'd40 : 9'd300;
         len_i = c == 0 ? 10'd3 : c == 6 ? 10'd5 : 10'd7;
         ready_i = 1;
         cyc();
      end
      start_i = 0;
      check("b2b_ndone", dones.size(), 2);
      check("b2b_done0", dones.size() > 0 ? dones[0] : -1, 6);
      check("b2b_done1", dones.size() > 1 ? dones[1] : -1, 14);
      check("b2b_nwords", words.size(), 8);
      for (int i = 0; i < 8 && i < words.size(); i++) check("b2b_word", words[i], exp_word(ea[i]));

      clear();
      start_i = 1; base_addr_i = 9'd200; len_i = 10'd10; ready_i = 1;
      cyc();
      start_i = 0;
      for (int i = 0; i < 5; i++) cyc();
      check("pre_reset_words", words.size(), 3);
      rst_i = 1;
      cyc(1);
      rst_i = 0;
      for (int i = 0; i < 4; i++) cyc(1);
      check("no_done_after_reset", dones.size(), 0);
      burst(300, 4, 0, 30);
      verify(300, 4);
      check("fresh_first_valid", first_v, 3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
